// File: rtl/sequenciador_exibicao_pkg.sv
// Shared definitions for the sequence playback controller: state codes shown on the
// debug display and the default timing parameters.
package sequenciador_exibicao_pkg;

    localparam int T_ACESO_PADRAO   = 500;
    localparam int T_APAGADO_PADRAO = 250;
    localparam int W_TEMPO_PADRAO   = 10;

    typedef enum logic [2:0] {
        OCIOSO  = 3'd0,
        CARREGA = 3'd1,
        ACESO   = 3'd2,
        APAGADO = 3'd3,
        FIM     = 3'd4
    } estado_t;

    // 4-bit code driven onto the 7-segment debug display.
    function automatic logic [3:0] codigo_estado(input estado_t estado);
        return {1'b0, estado};
    endfunction

endpackage

// File: rtl/sequenciador_exibicao_contador_tempo.sv
// Phase timer: up-counter with synchronous clear and enable; fim flags the last
// cycle of a phase that lasts 'limite' cycles.
module sequenciador_exibicao_contador_tempo
    import sequenciador_exibicao_pkg::*;
#(
    parameter int W_TEMPO = W_TEMPO_PADRAO
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               limpa,
    input  logic               conta,
    input  logic [W_TEMPO-1:0] limite,
    output logic               fim
);

    logic [W_TEMPO-1:0] contagem_q;
    logic [W_TEMPO-1:0] contagem_d;

    always_comb begin
        contagem_d = contagem_q;
        if (limpa) begin
            contagem_d = '0;
        end else if (conta) begin
            contagem_d = contagem_q + W_TEMPO'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value regardless of process evaluation order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            contagem_q <= '0;
        end else begin
            contagem_q <= contagem_d;
        end
    end

    assign fim = (contagem_q == (limite - W_TEMPO'(1)));

endmodule

// File: rtl/sequenciador_exibicao.sv
// Plays the current round's sequence on the leds: walks the ROM from address 0 to the
// latched limit, lighting each entry and then leaving a dark gap, then pulses fim_exibicao.
module sequenciador_exibicao
    import sequenciador_exibicao_pkg::*;
#(
    parameter int T_ACESO   = T_ACESO_PADRAO,
    parameter int T_APAGADO = T_APAGADO_PADRAO,
    parameter int W_TEMPO   = W_TEMPO_PADRAO
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       cancelar,
    input  logic       modo_rapido,
    input  logic [3:0] limite,
    input  logic [3:0] mem_dado,
    output logic [3:0] mem_endereco,
    output logic [3:0] leds,
    output logic       exibindo,
    output logic       fim_exibicao,
    output logic [3:0] db_estado
);

    localparam logic [W_TEMPO-1:0] TA_NORMAL = W_TEMPO'(T_ACESO);
    localparam logic [W_TEMPO-1:0] TA_RAPIDO = W_TEMPO'(T_ACESO >> 1);
    localparam logic [W_TEMPO-1:0] TP_NORMAL = W_TEMPO'(T_APAGADO);
    localparam logic [W_TEMPO-1:0] TP_RAPIDO = W_TEMPO'(T_APAGADO >> 1);

    estado_t    estado_q,   estado_d;
    logic [3:0] endereco_q, endereco_d;
    logic [3:0] leds_q,     leds_d;
    logic [3:0] limite_q,   limite_d;
    logic       rapido_q,   rapido_d;

    logic               limpa_tempo;
    logic               conta_tempo;
    logic               fim_tempo;
    logic [W_TEMPO-1:0] limite_tempo;

    always_comb begin
        if (estado_q == ACESO) begin
            limite_tempo = rapido_q ? TA_RAPIDO : TA_NORMAL;
        end else begin
            limite_tempo = rapido_q ? TP_RAPIDO : TP_NORMAL;
        end
    end

    // NOTE: every signal written here gets a default first; a path that leaves
    // one unassigned would infer a latch.
    always_comb begin
        estado_d   = estado_q;
        endereco_d = endereco_q;
        leds_d     = leds_q;
        limite_d   = limite_q;
        rapido_d   = rapido_q;

        unique case (estado_q)
            OCIOSO: begin
                if (iniciar) begin
                    limite_d   = limite;
                    rapido_d   = modo_rapido;
                    endereco_d = '0;
                    estado_d   = CARREGA;
                end
            end
            CARREGA: begin
                leds_d   = mem_dado;
                estado_d = ACESO;
            end
            ACESO: begin
                if (fim_tempo) begin
                    leds_d   = '0;
                    estado_d = APAGADO;
                end
            end
            APAGADO: begin
                if (fim_tempo) begin
                    if (endereco_q == limite_q) begin
                        estado_d = FIM;
                    end else begin
                        endereco_d = endereco_q + 4'd1;
                        estado_d   = CARREGA;
                    end
                end
            end
            FIM: begin
                estado_d = OCIOSO;
            end
            default: begin
                leds_d   = '0;
                estado_d = OCIOSO;
            end
        endcase

        // Abort overrides whatever the state decided, including a start in OCIOSO.
        if (cancelar) begin
            estado_d   = OCIOSO;
            leds_d     = '0;
            endereco_d = endereco_q;
            limite_d   = limite_q;
            rapido_d   = rapido_q;
        end
    end

    assign limpa_tempo = (estado_d != estado_q);
    assign conta_tempo = (estado_q == ACESO) || (estado_q == APAGADO);

    sequenciador_exibicao_contador_tempo #(
        .W_TEMPO (W_TEMPO)
    ) u_contador_tempo (
        .clock  (clock),
        .reset  (reset),
        .limpa  (limpa_tempo),
        .conta  (conta_tempo),
        .limite (limite_tempo),
        .fim    (fim_tempo)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q   <= OCIOSO;
            endereco_q <= '0;
            leds_q     <= '0;
            limite_q   <= '0;
            rapido_q   <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            endereco_q <= endereco_d;
            leds_q     <= leds_d;
            limite_q   <= limite_d;
            rapido_q   <= rapido_d;
        end
    end

    assign mem_endereco = endereco_q;
    assign leds         = leds_q;
    assign exibindo     = (estado_q != OCIOSO);
    assign fim_exibicao = (estado_q == FIM);
    assign db_estado    = codigo_estado(estado_q);

endmodule
